mem_xfer_unit: RTL and testbench

Load/store sequencer on the far side of the register file's `load`/`ldm`/`rw` interface. It moves a word from data memory into a selected register (x or y) and moves a selected register's value to data memory. It drives the register-file write strobe `ldm` and the register select `rw`, and consumes the registered register-file output `out`. Memory access uses a req/ack handshake with a bounded wait.

---
 rtl/mem_xfer_unit_if.sv | 28 ++
 rtl/mem_xfer_unit.sv | 141 ++++++++++++++
 tb/tb_mem_xfer_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_xfer_unit_if.sv
// Memory-side req/ack bus of the load/store sequencer.
// The sequencer drives the request side; the memory answers with ack and read data.
interface mem_xfer_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_xfer_unit.sv
// Load/store sequencer between the register file (load/ldm/rw/out) and data memory.
// Moves one word per transfer through IDLE -> SEL -> CAPT -> REQ -> DONE with a bounded ack wait.
module mem_xfer_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic        sel,
    input  logic [15:0] addr,
    input  logic [15:0] reg_data,
    output logic        rw,
    output logic [15:0] load,
    output logic        ldm,
    output logic        busy,
    output logic        done,
    output logic        err,
    mem_xfer_unit_if.master mem
);

    typedef enum logic [2:0] {StIdle, StSel, StCapt, StReq, StDone} state_e;

    localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [15:0] load_q, load_d;
    logic        ldm_q, ldm_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] maddr_q, maddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            addr_q  <= 16'h0000;
            rw_q    <= 1'b0;
            load_q  <= 16'h0000;
            ldm_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= 16'h0000;
            wdata_q <= 16'h0000;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            load_q  <= load_d;
            ldm_q   <= ldm_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        load_d  = load_q;
        ldm_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    addr_d  = addr;
                    rw_d    = sel;
                    state_d = StSel;
                end
            end
            // rw settles here so the registered register-file output is valid in CAPT.
            StSel: state_d = StCapt;
            StCapt: begin
                wdata_d = reg_data;
                maddr_d = addr_q;
                we_d    = op_q;
                req_d   = 1'b1;
                cnt_d   = 8'h00;
                state_d = StReq;
            end
            StReq: begin
                // Ack takes priority over a timeout firing in the same cycle.
                if (mem.mem_ack) begin
                    if (!op_q) begin
                        load_d = mem.mem_rdata;
                        ldm_d  = 1'b1;
                    end
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == CntMax) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign rw            = rw_q;
    assign load          = load_q;
    assign ldm           = ldm_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign err           = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_xfer_unit.sv
// Directed bench for mem_xfer_unit with TIMEOUT=4, a behavioural register file and a
// hand-driven memory responder; outputs are sampled on the falling edge.
module tb_mem_xfer_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] reg_data;
    logic        rw;
    logic [15:0] load;
    logic        ldm;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] rf_x, rf_y;
    int          done_cnt = 0;
    int          ldm_cnt = 0;
    int          n_checks = 0;
    int          n_errs = 0;

    mem_xfer_unit_if mif ();

    mem_xfer_unit #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .sel      (sel),
        .addr     (addr),
        .reg_data (reg_data),
        .rw       (rw),
        .load     (load),
        .ldm      (ldm),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem      (mif)
    );

    always #5 clk = ~clk;

    // Register file with registered output selected by rw.
    always @(posedge clk) begin
        if (rst) begin
            rf_x     <= 16'h1234;
            rf_y     <= 16'h0000;
            reg_data <= 16'h0000;
        end else begin
            if (ldm && !rw) rf_x <= load;
            if (ldm && rw)  rf_y <= load;
            reg_data <= rw ? rf_y : rf_x;
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (ldm)  ldm_cnt  <= ldm_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge of cycle n+1 (SEL).
    task automatic issue(input logic o, input logic s, input logic [15:0] a);
        start = 1'b1;
        op    = o;
        sel   = s;
        addr  = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in a REQ cycle; returns at the falling edge of the following (DONE) cycle.
    task automatic ack_pulse(input logic [15:0] d);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = d;
        @(negedge clk);
        mif.mem_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_cnt, idx, d0, l0;
        logic got, e_s, l_s;
        logic [15:0] ld_s;

        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 16'h0000;

        // Reset state
        cyc(2);
        check("rst_busy", busy, 0);
        check("rst_ctl", {rw, ldm, done, err, mif.mem_req, mif.mem_we}, 6'b0);
        check("rst_load", load, 16'h0000);
        check("rst_maddr", mif.mem_addr, 16'h0000);
        check("rst_wdata", mif.mem_wdata, 16'h0000);
        rst = 1'b0;
        cyc(1);

        // Load to y, ack in first REQ cycle
        issue(1'b0, 1'b1, 16'h0040);
        check("ld_sel_busy", busy, 1);
        check("ld_sel_rw", rw, 1);
        cyc(1);
        check("ld_capt_req", mif.mem_req, 0);
        cyc(1);
        check("ld_req", mif.mem_req, 1);
        check("ld_addr", mif.mem_addr, 16'h0040);
        check("ld_we", mif.mem_we, 0);
        ack_pulse(16'hBEEF);
        check("ld_done", {done, ldm, err}, 3'b110);
        check("ld_load", load, 16'hBEEF);
        check("ld_done_rw", rw, 1);
        check("ld_req_drop", mif.mem_req, 0);
        cyc(1);
        check("ld_idle", {busy, done, ldm}, 3'b000);
        cyc(1);
        check("ld_rf_out", reg_data, 16'hBEEF);

        // Store from x, ack in third REQ cycle
        l0 = ldm_cnt;
        issue(1'b1, 1'b0, 16'h0002);
        check("st_rw", rw, 0);
        cyc(2);
        check("st_req", mif.mem_req, 1);
        check("st_we", mif.mem_we, 1);
        check("st_wdata", mif.mem_wdata, 16'h1234);
        check("st_addr", mif.mem_addr, 16'h0002);
        cyc(2);
        check("st_req3", {mif.mem_req, done}, 2'b10);
        ack_pulse(16'h0000);
        check("st_done", {done, err, ldm}, 3'b100);
        cyc(1);
        check("st_no_ldm", ldm_cnt - l0, 0);

        // Timeout with no ack
        issue(1'b0, 1'b0, 16'h0010);
        req_cnt = 0; idx = -1; got = 1'b0; e_s = 1'b0; l_s = 1'b0; ld_s = 16'h0;
        for (int i = 0; i < 16; i++) begin
            if (mif.mem_req) req_cnt++;
            if (done) begin
                got = 1'b1; idx = i; e_s = err; l_s = ldm; ld_s = load;
                break;
            end
            @(negedge clk);
        end
        check("to_seen_done", got, 1);
        check("to_done_cycle", idx, 6);
        check("to_req_cycles", req_cnt, 4);
        check("to_err_ldm", {e_s, l_s}, 2'b10);
        check("to_load_kept", ld_s, 16'hBEEF);
        check("to_req_drop", mif.mem_req, 0);
        cyc(1);

        // Ack in the fourth (last) REQ cycle wins over the timeout
        issue(1'b0, 1'b0, 16'h0011);
        cyc(5);
        check("to4_req", mif.mem_req, 1);
        ack_pulse(16'h5A5A);
        check("to4_done", {done, err, ldm}, 3'b101);
        check("to4_load", load, 16'h5A5A);
        cyc(1);

        // start during REQ and mem_ack in IDLE are ignored
        d0 = done_cnt;
        issue(1'b0, 1'b1, 16'h0080);
        cyc(2);
        start = 1'b1; op = 1'b1; sel = 1'b0; addr = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        check("ign_rw", rw, 1);
        check("ign_addr", mif.mem_addr, 16'h0080);
        check("ign_we", mif.mem_we, 0);
        ack_pulse(16'h1111);
        check("ign_done", {done, ldm, rw}, 3'b111);
        check("ign_load", load, 16'h1111);
        cyc(1);
        ack_pulse(16'h2222);
        check("ign_idle", {busy, done, ldm}, 3'b000);
        check("ign_load_kept", load, 16'h1111);
        cyc(2);
        check("ign_busy_late", busy, 0);
        check("ign_done_cnt", done_cnt - d0, 1);

        // Reset asserted in the second REQ cycle
        issue(1'b0, 1'b1, 16'h0100);
        cyc(3);
        check("rq_req_before", mif.mem_req, 1);
        d0 = done_cnt; l0 = ldm_cnt;
        rst = 1'b1;
        #1;
        check("rq_async_req", mif.mem_req, 0);
        check("rq_async_busy", busy, 0);
        check("rq_async_rw", rw, 0);
        check("rq_async_load", load, 16'h0000);
        check("rq_async_maddr", mif.mem_addr, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        ack_pulse(16'hDEAD);
        cyc(1);
        check("rq_after", {busy, done, ldm}, 3'b000);
        check("rq_no_pulses", (done_cnt - d0) + (ldm_cnt - l0), 0);
        check("rq_load_zero", load, 16'h0000);
        issue(1'b0, 1'b0, 16'h0200);
        cyc(2);
        ack_pulse(16'hCAFE);
        check("rq_fresh_done", {done, err, ldm}, 3'b101);
        check("rq_fresh_load", load, 16'hCAFE);
        cyc(1);

        // Back-to-back: load y, then store x on the first IDLE cycle after DONE
        d0 = done_cnt;
        issue(1'b0, 1'b1, 16'h0300);
        cyc(2);
        ack_pulse(16'h7777);
        check("bb_ld_done", {done, ldm, rw}, 3'b111);
        cyc(1);
        issue(1'b1, 1'b0, 16'h0304);
        check("bb_st_rw", rw, 0);
        cyc(2);
        check("bb_st_wdata", mif.mem_wdata, 16'hCAFE);
        check("bb_st_addr", mif.mem_addr, 16'h0304);
        ack_pulse(16'h0000);
        check("bb_st_done", {done, ldm, rw}, 3'b100);
        cyc(2);
        check("bb_done_cnt", done_cnt - d0, 2);
        check("bb_y_written", rf_y, 16'h7777);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
